// File: rtl/bw_filter_if.sv
// Handshake and buffer-port bundle between the capture FSM, source BRAM, bw_image buffer and bw_filter.
// Latency: none (wires only).
// Backpressure: none; start/ack level handshake, read data follows the address by the BRAM latency.
// Signals: start/ack (control in), done/busy (status out), rd_addr/rd_data (source read port),
//          wr_en/wr_addr/wr_data (bw_image write port).
interface bw_filter_if #(
    parameter int ADDR_W = 17
);
    logic              start;
    logic              ack;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] rd_addr;
    logic [11:0]       rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [11:0]       wr_data;

    // Environment side: capture FSM plus the source BRAM read data.
    modport master (
        output start, ack, rd_data,
        input  done, busy, rd_addr, wr_en, wr_addr, wr_data
    );

    // Filter side.
    modport slave (
        input  start, ack, rd_data,
        output done, busy, rd_addr, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/bw_filter.sv
// Streams one frame from the source buffer, converts RGB444 to 4-bit luma, thresholds, writes bw_image.
// Latency: pixel read at RUN cycle i is written at cycle i+RD_LAT+1; done at FRAME_PIXELS+RD_LAT+1.
// Backpressure: none; 1 pixel/cycle, the run always completes once started (start level, done held until ack).
// Ports: clk, reset (async active-low), bus (bw_filter_if.slave: start/ack/done/busy, rd_addr/rd_data,
//        wr_en/wr_addr/wr_data).
// Build option: BW_FILTER_GRAY_EN defined -> wr_data = {luma,luma,luma} instead of black/white.
module bw_filter #(
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 17,
    parameter int RD_LAT       = 1,
    parameter int THRESHOLD    = 8
) (
    input  logic       clk,
    input  logic       reset,
    bw_filter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT);

    state_t            state_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [1:0]        drain_cnt_q;
    logic              busy_q;
    logic              done_q;

    // Valid/address pipe tracking each read through the BRAM latency.
    logic              pipe_vld_q  [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];

    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [11:0]       wr_data_q;
    logic [11:0]       wr_data_d;

    logic [3:0] pix_r;
    logic [3:0] pix_g;
    logic [3:0] pix_b;
    logic [6:0] luma_sum;
    logic [3:0] luma;

    assign pix_r = bus.rd_data[11:8];
    assign pix_g = bus.rd_data[7:4];
    assign pix_b = bus.rd_data[3:0];

    // 2R + 5G + B peaks at 120, so 7 bits suffice; >>3 truncates.
    assign luma_sum = 7'({pix_r, 1'b0}) + 7'({pix_g, 2'b00}) + 7'(pix_g) + 7'(pix_b);
    assign luma     = luma_sum[6:3];

`ifdef BW_FILTER_GRAY_EN
    assign wr_data_d = {luma, luma, luma};
`else
    localparam logic [3:0] THR = 4'(THRESHOLD);
    assign wr_data_d = (luma >= THR) ? 12'hFFF : 12'h000;
`endif

    // Control FSM; busy/done are registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            drain_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.ack) begin
                        state_q   <= RUN;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                RUN: begin
                    // Exit on the last address so the counter never wraps.
                    if (rd_addr_q == LAST_ADDR) begin
                        state_q     <= DRAIN;
                        drain_cnt_q <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // RD_LAT+1 cycles: BRAM latency plus the output register.
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + 2'd1;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read-latency pipe and output register. Reset clears the pipe so an
    // aborted frame leaves no write in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_vld_q[k]  <= 1'b0;
                pipe_addr_q[k] <= '0;
            end
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pipe_vld_q[0]  <= (state_q == RUN);
            pipe_addr_q[0] <= rd_addr_q;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k]  <= pipe_vld_q[k-1];
                pipe_addr_q[k] <= pipe_addr_q[k-1];
            end
            wr_en_q <= pipe_vld_q[RD_LAT-1];
            if (pipe_vld_q[RD_LAT-1]) begin
                wr_addr_q <= pipe_addr_q[RD_LAT-1];
                wr_data_q <= wr_data_d;
            end
        end
    end

    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
endmodule
